// File: rtl/digital_link_pkg.sv
// Shared definitions for the digital serial link (transmitter and receiver).
// Holds the link state encoding, default parameters and a counter sizing helper.
package digital_link_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } link_state_e;

    localparam int DEFAULT_CLK_DIV         = 20;
    localparam int DEFAULT_WORD_WIDTH      = 12;
    localparam int DEFAULT_WORDS_PER_FRAME = 16;

    // Counters for a limit of 1 still need one bit to exist at all.
    function automatic int counter_width(input int limit);
        return (limit <= 1) ? 1 : $clog2(limit);
    endfunction

endpackage

// File: rtl/dclk_gen.sv
// Serial bit clock generator: dclk is low for CLK_DIV cycles, then high for CLK_DIV cycles.
// boundary pulses in the last cycle of each bit, just before dclk falls.
module dclk_gen
    import digital_link_pkg::*;
#(
    parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
    input  logic clk80,
    input  logic rst,
    input  logic run,
    output logic dclk,
    output logic boundary
);

    localparam logic [7:0] PHASE_LAST = 8'(CLK_DIV - 1);

    logic [7:0] phase_q;
    logic [7:0] phase_d;
    logic       dclk_q;
    logic       dclk_d;

    always_comb begin
        phase_d = 8'd0;
        dclk_d  = 1'b0;
        if (run) begin
            if (phase_q == PHASE_LAST) begin
                phase_d = 8'd0;
                dclk_d  = ~dclk_q;
            end else begin
                phase_d = phase_q + 8'd1;
                dclk_d  = dclk_q;
            end
        end
    end

    always_ff @(posedge clk80 or negedge rst) begin
        if (!rst) begin
            phase_q <= 8'd0;
            dclk_q  <= 1'b0;
        end else begin
            phase_q <= phase_d;
            dclk_q  <= dclk_d;
        end
    end

    assign dclk     = dclk_q;
    assign boundary = run && dclk_q && (phase_q == PHASE_LAST);

endmodule

// File: rtl/digital_transmitter.sv
// Framed serial transmitter: shifts WORD_WIDTH-bit words MSB first on dDAT, clocked by dCLK,
// with a frame marker on bit 0 of word 0 and zero-substitution when no word is offered.
module digital_transmitter
    import digital_link_pkg::*;
#(
    parameter int CLK_DIV         = DEFAULT_CLK_DIV,
    parameter int WORD_WIDTH      = DEFAULT_WORD_WIDTH,
    parameter int WORDS_PER_FRAME = DEFAULT_WORDS_PER_FRAME
) (
    input  logic                  clk80,
    input  logic                  rst,
    input  logic                  en,
    input  logic [WORD_WIDTH-1:0] wordData,
    input  logic                  wordValid,
    output logic                  wordReady,
    output logic                  dCLK,
    output logic                  dDAT,
    output logic                  dFM,
    output logic                  busy,
    output logic [7:0]            underrunCnt
);

    localparam int BIT_W  = counter_width(WORD_WIDTH);
    localparam int WORD_W = counter_width(WORDS_PER_FRAME);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(WORD_WIDTH - 1);
    localparam logic [WORD_W-1:0] WORD_LAST = WORD_W'(WORDS_PER_FRAME - 1);

    link_state_e           state_q;
    link_state_e           state_d;
    logic [BIT_W-1:0]      bit_q;
    logic [BIT_W-1:0]      bit_d;
    logic [WORD_W-1:0]     word_q;
    logic [WORD_W-1:0]     word_d;
    logic [WORD_WIDTH-1:0] shift_q;
    logic [WORD_WIDTH-1:0] shift_d;
    logic                  dfm_q;
    logic                  dfm_d;
    logic                  ready_q;
    logic                  ready_d;
    logic [7:0]            underrun_q;
    logic [7:0]            underrun_d;

    logic run;
    logic boundary;
    logic dclk;
    logic load_word;
    logic first_word;

    assign run = (state_q == RUN);

    dclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_dclk_gen (
        .clk80    (clk80),
        .rst      (rst),
        .run      (run),
        .dclk     (dclk),
        .boundary (boundary)
    );

    always_comb begin
        state_d    = state_q;
        bit_d      = bit_q;
        word_d     = word_q;
        shift_d    = shift_q;
        dfm_d      = dfm_q;
        ready_d    = 1'b0;
        underrun_d = underrun_q;
        load_word  = 1'b0;
        first_word = 1'b0;

        case (state_q)
            IDLE: begin
                bit_d   = '0;
                word_d  = '0;
                shift_d = '0;
                dfm_d   = 1'b0;
                if (en) begin
                    state_d    = RUN;
                    load_word  = 1'b1;
                    first_word = 1'b1;
                end
            end
            RUN: begin
                if (boundary) begin
                    if (bit_q != BIT_LAST) begin
                        bit_d   = bit_q + BIT_W'(1);
                        shift_d = shift_q << 1;
                        dfm_d   = 1'b0;
                    end else begin
                        bit_d = '0;
                        if (word_q != WORD_LAST) begin
                            word_d    = word_q + WORD_W'(1);
                            load_word = 1'b1;
                        end else if (en) begin
                            // en is only honoured here, so a frame is never cut short.
                            word_d     = '0;
                            load_word  = 1'b1;
                            first_word = 1'b1;
                        end else begin
                            state_d = IDLE;
                            word_d  = '0;
                            shift_d = '0;
                            dfm_d   = 1'b0;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (load_word) begin
            dfm_d = first_word;
            if (wordValid) begin
                shift_d = wordData;
                ready_d = 1'b1;
            end else begin
                shift_d = '0;
                if (underrun_q != 8'hFF) begin
                    underrun_d = underrun_q + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clk80 or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            bit_q      <= '0;
            word_q     <= '0;
            shift_q    <= '0;
            dfm_q      <= 1'b0;
            ready_q    <= 1'b0;
            underrun_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            bit_q      <= bit_d;
            word_q     <= word_d;
            shift_q    <= shift_d;
            dfm_q      <= dfm_d;
            ready_q    <= ready_d;
            underrun_q <= underrun_d;
        end
    end

    assign dCLK        = dclk;
    assign dDAT        = shift_q[WORD_WIDTH-1];
    assign dFM         = dfm_q;
    assign busy        = run;
    assign wordReady   = ready_q;
    assign underrunCnt = underrun_q;

endmodule
